// File: rtl/ctrl_pkg.sv
// Shared encodings and the E-stage control word for the camera-datapath decoder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ctrl_pkg;

  // Opcodes
  localparam logic [1:0] OPDATA   = 2'b00;
  localparam logic [1:0] OPMEMORY = 2'b01;
  localparam logic [1:0] OPBRANCH = 2'b10;

  // cmd field (funct[4:1])
  localparam logic [3:0] FNOP      = 4'b0000;
  localparam logic [3:0] FADD      = 4'b0001;
  localparam logic [3:0] FSUB      = 4'b0010;
  localparam logic [3:0] FMULT     = 4'b0011;
  localparam logic [3:0] FLOAD     = 4'b0100;
  localparam logic [3:0] FSTR      = 4'b0101;
  localparam logic [3:0] FAVERAGE  = 4'b0110;
  localparam logic [3:0] FSTR_ONE  = 4'b0111;
  localparam logic [3:0] FB        = 4'b1000;

  // ALU operations
  localparam int         CTRL_ALU_W = 4;
  localparam logic [3:0] ALU_NOP    = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_SUB    = 4'd2;
  localparam logic [3:0] ALU_MULT   = 4'd3;
  localparam logic [3:0] ALU_BUFFER = 4'd4;
  localparam logic [3:0] ALU_AV     = 4'd5;

  // Everything the Execute stage consumes from decode.
  typedef struct packed {
    logic [CTRL_ALU_W-1:0] aluctl;
    logic [1:0]            flagw;
    logic                  alusrc;
    logic                  memtoreg;
    logic                  regwrite;
    logic                  memwrite;
    logic                  branch;
    logic                  pcsrc;
    logic                  plusone;
    logic                  valid;
    logic                  illegal;
  } ctrl_word_t;

  // Bubble: everything off, ALU idle.
  localparam ctrl_word_t CTRL_BUBBLE = '{aluctl: ALU_NOP, default: 1'b0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder producing the E-stage control word and D-stage selects.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the word is registered.
// Ports: i_funct/i_opcode/i_instr_valid in; o_word (E controls), o_regsrc_d, o_immsrc_d,
//        o_burst (instruction is a multi-beat candidate) out.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [FUNCT_W-1:0] i_funct,
  input  logic [1:0]         i_opcode,
  input  logic               i_instr_valid,
  output ctrl_word_t         o_word,
  output logic [1:0]         o_regsrc_d,
  output logic [1:0]         o_immsrc_d,
  output logic               o_burst
);

  logic [3:0] w_cmd;
  logic       w_s;
  logic       w_i;
  logic       w_opmem;
  logic       w_illegal;

  assign w_cmd     = i_funct[4:1];
  assign w_s       = i_funct[0];
  assign w_i       = i_funct[5];
  assign w_opmem   = (i_opcode == OPMEMORY);
  assign w_illegal = (i_opcode == 2'b11) || (w_cmd > FB);

  // D-stage selects are raw field decodes; they only steer muxes in Decode.
  assign o_regsrc_d = {w_opmem & ~w_s, i_opcode == OPBRANCH};
  assign o_immsrc_d = {w_cmd == FB, (w_cmd == FSTR) || (w_cmd == FLOAD)};

  always_comb begin
    o_word  = CTRL_BUBBLE;
    o_burst = 1'b0;
    if (i_instr_valid) begin
      if (w_illegal) begin
        // Illegal commands become a flagged bubble: no writes of any kind.
        o_word.illegal = 1'b1;
      end else begin
        case (w_cmd)
          FADD:                  o_word.aluctl = ALU_ADD;
          FSUB:                  o_word.aluctl = ALU_SUB;
          FMULT:                 o_word.aluctl = ALU_MULT;
          FLOAD, FSTR, FSTR_ONE: o_word.aluctl = ALU_BUFFER;
          FAVERAGE:              o_word.aluctl = ALU_AV;
          default:               o_word.aluctl = ALU_NOP;
        endcase
        o_word.memtoreg = w_opmem & (w_cmd == FLOAD);
        o_word.memwrite = w_opmem & ~w_s;
        o_word.regwrite = ~((w_cmd == FSTR) ||
                            ((w_cmd == FSTR_ONE) && !w_s) ||
                            ((i_opcode == OPDATA) && (w_cmd == FNOP)));
        o_word.flagw    = {w_s, w_s & ((o_word.aluctl == ALU_ADD) || (o_word.aluctl == ALU_SUB))};
        o_word.branch   = (i_opcode == OPBRANCH);
        o_word.pcsrc    = (i_opcode == OPBRANCH);
        o_word.alusrc   = w_i;
        o_word.plusone  = w_opmem & (w_cmd == FSTR_ONE);
        o_word.valid    = 1'b1;
        o_burst         = (w_cmd == FSTR_ONE) || (w_cmd == FAVERAGE);
      end
    end
  end

endmodule

// File: rtl/ctrl_burst_decoder.sv
// Decode control unit with D->E pipeline register; expands burst cmds into N E-stage micro-ops.
// Latency: 1 cycle D->E; an N-beat burst occupies N consecutive non-stalled E cycles.
// Backpressure: stall_e freezes E and the sequencer; busy_d holds fetch/decode during a burst.
// Ports: funct/opcode/instr_valid/burst_len (D-stage), stall_e/flush_e (hazard unit) in;
//        regsrc_d/immsrc_d (comb), busy_d (comb from state), registered *_e controls and beat_e out.
module ctrl_burst_decoder
  import ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUCTL_W  = 4,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [1:0]          opcode,
  input  logic                instr_valid,
  input  logic [CNT_W-1:0]    burst_len,
  input  logic                stall_e,
  input  logic                flush_e,
  output logic [1:0]          regsrc_d,
  output logic [1:0]          immsrc_d,
  output logic                busy_d,
  output logic                alusrc_e,
  output logic                memtoreg_e,
  output logic                regwrite_e,
  output logic                memwrite_e,
  output logic                branch_e,
  output logic                pcsrc_e,
  output logic                plusone_e,
  output logic                valid_e,
  output logic                illegal_e,
  output logic [ALUCTL_W-1:0] aluctl_e,
  output logic [1:0]          flagw_e,
  output logic [CNT_W-1:0]    beat_e
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  ctrl_word_t       w_word;
  logic             w_burst;
  logic [CNT_W-1:0] w_len;

  state_t           r_state;
  ctrl_word_t       r_lat;
  ctrl_word_t       r_e;
  logic [CNT_W-1:0] r_beat;
  logic [CNT_W-1:0] r_remaining;

  ctrl_decode #(.FUNCT_W(FUNCT_W)) u_decode (
    .i_funct       (funct),
    .i_opcode      (opcode),
    .i_instr_valid (instr_valid),
    .o_word        (w_word),
    .o_regsrc_d    (regsrc_d),
    .o_immsrc_d    (immsrc_d),
    .o_burst       (w_burst)
  );

  // Effective beat count: 0 means a single beat, oversize requests saturate.
  always_comb begin
    w_len = burst_len;
    if (burst_len == '0)          w_len = ONE;
    else if (burst_len > MAX_LEN) w_len = MAX_LEN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lat       <= CTRL_BUBBLE;
      r_e         <= CTRL_BUBBLE;
      r_beat      <= '0;
      r_remaining <= '0;
    end else if (flush_e) begin
      // Flush drops any burst in flight; it is not resumed.
      r_state     <= S_IDLE;
      r_e         <= CTRL_BUBBLE;
      r_beat      <= '0;
      r_remaining <= '0;
    end else if (!stall_e) begin
      case (r_state)
        S_IDLE: begin
          r_e    <= w_word;
          r_beat <= '0;
          if (w_burst && (w_len > ONE)) begin
            // Beat 0 is never the last beat, so its flag write is held off.
            r_e.flagw   <= 2'b00;
            r_lat       <= w_word;
            r_remaining <= w_len - ONE;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          // D-stage inputs are ignored; replay the latched word.
          r_e         <= r_lat;
          if (r_remaining != ONE) r_e.flagw <= 2'b00;
          r_beat      <= r_beat + ONE;
          r_remaining <= r_remaining - ONE;
          if (r_remaining == ONE) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_d     = (r_state == S_BURST);
  assign alusrc_e   = r_e.alusrc;
  assign memtoreg_e = r_e.memtoreg;
  assign regwrite_e = r_e.regwrite;
  assign memwrite_e = r_e.memwrite;
  assign branch_e   = r_e.branch;
  assign pcsrc_e    = r_e.pcsrc;
  assign plusone_e  = r_e.plusone;
  assign valid_e    = r_e.valid;
  assign illegal_e  = r_e.illegal;
  assign aluctl_e   = ALUCTL_W'(r_e.aluctl);
  assign flagw_e    = r_e.flagw;
  assign beat_e     = r_beat;

endmodule

// File: tb/tb_ctrl_burst_decoder.sv
// Self-checking bench for ctrl_burst_decoder: decode vector table, burst/stall/flush/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_ctrl_burst_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] funct = '0;
  logic [1:0] opcode = '0;
  logic       instr_valid = 1'b0;
  logic [3:0] burst_len = '0;
  logic       stall_e = 1'b0;
  logic       flush_e = 1'b0;
  logic [1:0] regsrc_d, immsrc_d;
  logic       busy_d, alusrc_e, memtoreg_e, regwrite_e, memwrite_e, branch_e, pcsrc_e;
  logic       plusone_e, valid_e, illegal_e;
  logic [3:0] aluctl_e;
  logic [1:0] flagw_e;
  logic [3:0] beat_e;

  ctrl_burst_decoder dut (
    .clk(clk), .rst_n(rst_n), .funct(funct), .opcode(opcode), .instr_valid(instr_valid),
    .burst_len(burst_len), .stall_e(stall_e), .flush_e(flush_e),
    .regsrc_d(regsrc_d), .immsrc_d(immsrc_d), .busy_d(busy_d),
    .alusrc_e(alusrc_e), .memtoreg_e(memtoreg_e), .regwrite_e(regwrite_e),
    .memwrite_e(memwrite_e), .branch_e(branch_e), .pcsrc_e(pcsrc_e), .plusone_e(plusone_e),
    .valid_e(valid_e), .illegal_e(illegal_e), .aluctl_e(aluctl_e), .flagw_e(flagw_e),
    .beat_e(beat_e)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] fw;
    logic       alusrc, memtoreg, regwrite, memwrite, branch, pcsrc, plusone, valid, illegal;
    logic [3:0] beat;
  } ew_t;

  int  n_checks = 0;
  int  n_errors = 0;
  ew_t m_e = '0;
  ew_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ew_t act_e();
    return {aluctl_e, flagw_e, alusrc_e, memtoreg_e, regwrite_e, memwrite_e, branch_e,
            pcsrc_e, plusone_e, valid_e, illegal_e, beat_e};
  endfunction

  // Reference decode written straight from the encoding rules.
  function automatic ew_t ref_dec(input logic [1:0] op, input logic [5:0] fn, input logic v);
    ew_t        w;
    logic [3:0] cmd;
    logic       s;
    w   = '0;
    cmd = fn[4:1];
    s   = fn[0];
    if (!v) return w;
    if (op == 2'd3 || cmd > 4'd8) begin
      w.illegal = 1'b1;
      return w;
    end
    if (cmd <= 4'd3)       w.alu = cmd;
    else if (cmd == 4'd6)  w.alu = 4'd5;
    else if (cmd != 4'd8)  w.alu = 4'd4;
    w.memtoreg = (op == 2'd1) && (cmd == 4'd4);
    w.memwrite = (op == 2'd1) && !s;
    w.regwrite = !((cmd == 4'd5) || (cmd == 4'd7 && !s) || (op == 2'd0 && cmd == 4'd0));
    w.fw       = {s, s && (w.alu == 4'd1 || w.alu == 4'd2)};
    w.branch   = (op == 2'd2);
    w.pcsrc    = (op == 2'd2);
    w.alusrc   = fn[5];
    w.plusone  = (op == 2'd1) && (cmd == 4'd7);
    w.valid    = 1'b1;
    return w;
  endfunction

  function automatic int ref_len(input logic [1:0] op, input logic [5:0] fn, input logic v,
                                 input logic [3:0] len);
    ew_t w;
    w = ref_dec(op, fn, v);
    if (!w.valid || !(fn[4:1] == 4'd6 || fn[4:1] == 4'd7)) return 1;
    if (len == 4'd0) return 1;
    if (int'(len) > 8) return 8;
    return int'(len);
  endfunction

  // Model of one clock edge: pending burst beats sit in a queue ahead of new decodes.
  task automatic model_edge();
    ew_t w, b;
    int  n;
    if (flush_e) begin
      m_e = '0;
      q.delete();
    end else if (!stall_e) begin
      if (q.size() != 0) begin
        m_e = q.pop_front();
      end else begin
        w = ref_dec(opcode, funct, instr_valid);
        n = ref_len(opcode, funct, instr_valid, burst_len);
        if (n > 1) begin
          for (int k = 1; k < n; k++) begin
            b      = w;
            b.beat = 4'(k);
            if (k != n - 1) b.fw = 2'b00;
            q.push_back(b);
          end
          w.fw = 2'b00;
        end
        m_e = w;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("e_word", 32'(act_e()), 32'(m_e));
    chk("busy_d", 32'(busy_d), 32'(q.size() != 0));
  endtask

  task automatic set_in(input logic [1:0] op, input logic [5:0] fn, input logic v,
                        input logic [3:0] len);
    opcode = op; funct = fn; instr_valid = v; burst_len = len;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic       v;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       rw, mw, ill, ve;
  } vec_t;

  vec_t vt[12];

  initial begin
    int busy_cnt;
    int bexp[6];
    int stl[6];
    vt[0]  = '{2'b00, 6'b000011, 1'b1, 4'd1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1}; // ADDS
    vt[1]  = '{2'b00, 6'b011110, 1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}; // cmd 1111
    vt[2]  = '{2'b00, 6'b100100, 1'b1, 4'd2, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1}; // SUB imm
    vt[3]  = '{2'b00, 6'b000111, 1'b1, 4'd3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1}; // MULTS
    vt[4]  = '{2'b01, 6'b001001, 1'b1, 4'd4, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1}; // LOAD S=1
    vt[5]  = '{2'b01, 6'b001010, 1'b1, 4'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1}; // STR
    vt[6]  = '{2'b00, 6'b000000, 1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}; // NOP
    vt[7]  = '{2'b11, 6'b000010, 1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}; // opcode 11
    vt[8]  = '{2'b10, 6'b010000, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1}; // B
    vt[9]  = '{2'b00, 6'b000011, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // not valid
    vt[10] = '{2'b00, 6'b001100, 1'b1, 4'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1}; // AVERAGE len1
    vt[11] = '{2'b00, 6'b000101, 1'b1, 4'd2, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1}; // SUBS

    // Reset state
    #3;
    chk("rst_e_word", 32'(act_e()), 32'(0));
    chk("rst_busy", 32'(busy_d), 32'(0));
    #9 rst_n = 1'b1;

    // Decode table, each vector as a single beat
    foreach (vt[i]) begin
      set_in(vt[i].op, vt[i].fn, vt[i].v, 4'd1);
      step();
      chk($sformatf("vec%0d", i),
          32'({aluctl_e, flagw_e, regwrite_e, memwrite_e, illegal_e, valid_e}),
          32'({vt[i].alu, vt[i].fw, vt[i].rw, vt[i].mw, vt[i].ill, vt[i].ve}));
    end
    set_in(2'b00, 6'b000000, 1'b0, 4'd0);
    step();

    // 4-beat FSTR_ONE store burst
    set_in(2'b01, 6'b001110, 1'b1, 4'd4);
    #1;
    chk("regsrc_d_str1", 32'(regsrc_d), 32'(2'b10));
    chk("immsrc_d_str1", 32'(immsrc_d), 32'(2'b00));
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      instr_valid = 1'b0;
      chk($sformatf("burst_beat%0d", i), 32'(beat_e), 32'(i));
      chk($sformatf("burst_pm%0d", i), 32'({plusone_e, memwrite_e, valid_e}), 32'(3'b111));
      if (busy_d) busy_cnt++;
    end
    chk("burst_busy_cycles", 32'(busy_cnt), 32'(3));
    step();
    chk("burst_after_valid", 32'(valid_e), 32'(0));

    // Same burst with a 2-cycle stall at beat 1
    bexp = '{0, 1, 1, 1, 2, 3};
    stl  = '{0, 0, 1, 1, 0, 0};
    set_in(2'b01, 6'b001110, 1'b1, 4'd4);
    for (int i = 0; i < 6; i++) begin
      stall_e = stl[i][0];
      step();
      instr_valid = 1'b0;
      chk($sformatf("stall_beat%0d", i), 32'(beat_e), 32'(bexp[i]));
      chk($sformatf("stall_busy%0d", i), 32'(busy_d), 32'(i < 5));
    end
    stall_e = 1'b0;
    step();

    // Flush at beat 2 of 4
    set_in(2'b01, 6'b001110, 1'b1, 4'd4);
    step();
    instr_valid = 1'b0;
    step();
    chk("flush_pre_beat", 32'(beat_e), 32'(1));
    flush_e = 1'b1;
    step();
    flush_e = 1'b0;
    chk("flush_bubble", 32'({valid_e, beat_e, busy_d}), 32'(0));
    step();
    chk("flush_idle", 32'({valid_e, busy_d}), 32'(0));

    // Asynchronous reset mid-burst, then burst_len=0 issues one beat
    set_in(2'b01, 6'b001110, 1'b1, 4'd4);
    step();
    instr_valid = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1;
    m_e = '0;
    q.delete();
    chk("arst_e_word", 32'(act_e()), 32'(0));
    chk("arst_busy", 32'(busy_d), 32'(0));
    rst_n = 1'b1;
    set_in(2'b01, 6'b001110, 1'b1, 4'd0);
    step();
    instr_valid = 1'b0;
    chk("len0_beat", 32'({valid_e, beat_e, busy_d}), 32'({1'b1, 4'd0, 1'b0}));
    step();
    chk("len0_single", 32'({valid_e, busy_d}), 32'(0));

    // Randomized run against the model
    for (int c = 0; c < 800; c++) begin
      funct = 6'($urandom);
      if ($urandom_range(0, 1) == 1) funct[4:1] = ($urandom_range(0, 1) == 1) ? 4'd6 : 4'd7;
      opcode      = 2'($urandom_range(0, 3));
      instr_valid = ($urandom_range(0, 3) != 0);
      burst_len   = 4'($urandom_range(0, 15));
      stall_e     = ($urandom_range(0, 5) == 0);
      flush_e     = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd_regsrc", 32'(regsrc_d),
          32'({opcode == 2'd1 && !funct[0], opcode == 2'd2}));
      chk("rnd_immsrc", 32'(immsrc_d),
          32'({funct[4:1] == 4'd8, funct[4:1] == 4'd5 || funct[4:1] == 4'd4}));
      step();
    end
    stall_e = 1'b0;
    flush_e = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_burst_decoder.md
# ctrl_burst_decoder

Decode-stage control unit with an integrated D→E pipeline register and a burst sequencer for the camera datapath. It decodes `opcode`/`funct` into datapath controls exactly once per instruction and registers them into the Execute stage, honouring hazard-unit stall and flush. Burst instructions (`FSTR_ONE`, `FAVERAGE`) are expanded into N back-to-back Execute micro-ops, with the decode stage held busy meanwhile. Illegal commands decode to a safe bubble with an `illegal_e` flag, never to high-Z.

## Interface
- `FUNCT_W`, default 6: funct field width; cmd = `funct[4:1]`, S-bit = `funct[0]`, I-bit = `funct[5]`.
- `ALUCTL_W`, default 4: ALU control width.
- `MAX_BURST`, default 8: maximum micro-ops per burst instruction.
- `CNT_W`, default `$clog2(MAX_BURST+1)`: burst length/index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `funct` in FUNCT_W: decode-stage funct.
- `opcode` in 2: decode-stage opcode.
- `instr_valid` in 1: D-stage holds a real instruction.
- `burst_len` in CNT_W: requested beats; 0 → 1; values above MAX_BURST are clamped to MAX_BURST.
- `stall_e` in 1: hold all E-stage registers and sequencer state.
- `flush_e` in 1: load a bubble into E; aborts any burst.
- `regsrc_d` out 2: combinational, D-stage.
- `immsrc_d` out 2: combinational, D-stage.
- `busy_d` out 1: hold fetch/decode; the sequencer owns E.
- `alusrc_e`, `memtoreg_e`, `regwrite_e`, `memwrite_e`, `branch_e`, `pcsrc_e`, `plusone_e`, `valid_e`, `illegal_e` out 1 each: registered.
- `aluctl_e` out ALUCTL_W: registered.
- `flagw_e` out 2: registered.
- `beat_e` out CNT_W: registered; micro-op index within the burst.

## Operation
- Shared encodings:
  - Opcodes: OPDATA=00, OPMEMORY=01, OPBRANCH=10.
  - cmds: FNOP=0000, FADD=0001, FSUB=0010, FMULT=0011, FLOAD=0100, FSTR=0101, FAVERAGE=0110, FSTR_ONE=0111, FB=1000.
  - ALU ops: NOP=0, ADD=1, SUB=2, MULT=3, BUFFER=4, AV=5.
- cmd→aluctl: NOP/ADD/SUB/MULT map directly; LOAD, STR and STR_ONE → BUFFER; AVERAGE → AV.
- Any other cmd, or opcode=11: aluctl=NOP, all write enables 0, `illegal_e`=1.
- `memtoreg` = OPMEMORY & FLOAD.
- `memwrite` = OPMEMORY & ~S.
- `regwrite` = ~(FSTR | FSTR_ONE-store | OPDATA&FNOP | illegal).
- `flagw[1]` = S; `flagw[0]` = S & (aluctl∈{ADD,SUB}).
- `branch` = `pcsrc` = OPBRANCH; `alusrc` = I-bit.
- `regsrc_d` = {OPMEMORY&~S, OPBRANCH}; `immsrc_d` = {FB, FSTR|FLOAD}.
- `plusone` = OPMEMORY & FSTR_ONE.
- `instr_valid`=0 decodes to a bubble: all enables 0, `valid_e`=0.
- A bubble has every E output 0 except `aluctl_e`=NOP.
- FSM has two states, IDLE and BURST:
  - **IDLE → BURST**: entered on a non-stalled edge when the instruction is valid, is a burst cmd, and has len>1. On that edge:
    - E is loaded with beat 0.
    - The decoded control word is latched.
    - `remaining` is set to len−1.
  - **In BURST**: each non-stalled edge issues the next beat with the latched control and `beat_e`+1.
    - The S-bit flag write is suppressed on all beats except the last.
  - **BURST → IDLE**: taken on the edge that issues the last beat.
  - A burst cmd with len≤1 is issued as a single ordinary instruction.
- `busy_d` = (state==BURST), combinational from state.
- D-stage inputs are ignored while in BURST.
- `flush_e` takes priority over everything:
  - The E bubble is loaded and the FSM goes to IDLE.
  - The burst is dropped, not resumed.
- `stall_e` (without flush) freezes all registers and the FSM.

## Timing
- D→E latency: 1 cycle.
- An N-beat burst occupies N consecutive non-stalled E cycles.
- `busy_d` is high for N−1 cycles, starting the cycle after beat 0 issues.
- Reset state:
  - FSM=IDLE, counters 0.
  - All E outputs 0 except `aluctl_e`=NOP.
  - `busy_d`=0.
- Reset asserted mid-burst returns to IDLE immediately, asynchronously.
- Precedence when signals coincide: reset > flush > stall.

## Structure
- Package `ctrl_pkg` holds:
  - Opcode, cmd and ALU-op localparams.
  - A packed struct `ctrl_word_t` containing all E-stage fields.
- Sub-module `ctrl_decode` is purely combinational: funct/opcode → `ctrl_word_t` plus the D-stage fields.
- The top level holds the E register, the burst FSM and the counters.

## Test plan
- ADDS on OPDATA (funct=000011), valid → next cycle: `aluctl_e`=1, `flagw_e`=11, `regwrite_e`=1, `valid_e`=1.
- FSTR_ONE store (opcode=01, funct=001110), `burst_len`=4 → `beat_e` 0,1,2,3 on four consecutive cycles, `plusone_e`=1 and `memwrite_e`=1 each beat, `busy_d` high for 3 cycles.
- Same 4-beat burst with `stall_e` high for 2 cycles at beat 1 → beat 1 holds 3 cycles total, `busy_d` stays high, no beat skipped or repeated.
- `flush_e` asserted at beat 2 of 4 → E gets a bubble (`valid_e`=0), FSM returns to IDLE, `busy_d`=0 next cycle.
- cmd=1111 on OPDATA → `illegal_e`=1, `regwrite_e`=0, `memwrite_e`=0, `aluctl_e`=0.
- `rst_n` pulled low mid-burst, asynchronously → all outputs at reset values before the next edge; `burst_len`=0 after reset issues exactly one beat.
